// File: rtl/audio_clock_regeneration_receiver.sv
// ACR packet sink: validates N/CTS from Audio Clock Regeneration packets, tracks lock,
// and regenerates a 128*fs clock enable plus fs sample strobe from the pixel clock.
module audio_clock_regeneration_receiver #(
  parameter int unsigned LOCK_COUNT     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4194304
) (
  input  logic        clk_pixel,
  input  logic        reset_n,
  input  logic        packet_valid,
  input  logic [23:0] header,
  input  logic [55:0] sub [4],
  output logic [19:0] n_value,
  output logic [19:0] cts_value,
  output logic        acr_locked,
  output logic        clk_audio_x128_en,
  output logic        sample_strobe,
  output logic        packet_error
);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned MW = $clog2(LOCK_COUNT + 1) + 1;

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_e;

  state_e        state_q, state_d;
  logic [19:0]   n_q, n_d, cts_q, cts_d;
  logic [MW-1:0] match_q, match_d;
  logic [TW-1:0] to_q, to_d;
  logic [20:0]   acc_q, acc_d;
  logic [6:0]    cnt_q, cnt_d;
  logic          pulse_q, pulse_d, strobe_q, strobe_d, err_q, err_d;

  logic [19:0]   pkt_n, pkt_cts;
  logic [20:0]   sum;
  logic          is_acr, fmt_ok, accept, same, expired, run;
  logic          unused_hb;

  assign unused_hb = ^header[23:8];

  assign pkt_n   = {sub[0][35:32], sub[0][47:40], sub[0][55:48]};
  assign pkt_cts = {sub[0][11:8],  sub[0][23:16], sub[0][31:24]};
  assign fmt_ok  = (sub[1] == sub[0]) && (sub[2] == sub[0]) && (sub[3] == sub[0]) &&
                   (sub[0][39:36] == '0) && (sub[0][15:12] == '0) && (sub[0][7:0] == '0) &&
                   (pkt_n != '0) && (pkt_cts != '0) && (pkt_n < pkt_cts);
  assign is_acr  = packet_valid && (header[7:0] == 8'h01);
  assign accept  = is_acr && fmt_ok;
  assign same    = (pkt_n == n_q) && (pkt_cts == cts_q);
  assign expired = (to_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      n_q      <= '0;
      cts_q    <= '0;
      match_q  <= '0;
      to_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      cts_q    <= cts_d;
      match_q  <= match_d;
      to_q     <= to_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
    end
  end

  // An accepted packet always takes priority over timeout expiry in the same cycle.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cts_d   = cts_q;
    match_d = match_q;
    err_d   = is_acr && !fmt_ok;
    to_d    = accept ? '0 : (expired ? to_q : to_q + TW'(1));
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          n_d     = pkt_n;
          cts_d   = pkt_cts;
          match_d = MW'(1);
          state_d = (LOCK_COUNT <= 1) ? LOCKED : ACQUIRE;
        end
        ACQUIRE: begin
          if (same) begin
            match_d = match_q + MW'(1);
            if (match_q + MW'(1) >= MW'(LOCK_COUNT)) state_d = LOCKED;
          end else begin
            n_d     = pkt_n;
            cts_d   = pkt_cts;
            match_d = MW'(1);
          end
        end
        LOCKED: begin
          if (!same) begin
            n_d     = pkt_n;
            cts_d   = pkt_cts;
            match_d = MW'(1);
            state_d = ACQUIRE;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && expired) begin
      state_d = IDLE;
    end
  end

  // Generation only runs across cycles that stay locked, so no pulse can land after unlock.
  assign run = (state_q == LOCKED) && (state_d == LOCKED);
  assign sum = acc_q + {1'b0, n_q};

  always_comb begin
    acc_d    = '0;
    cnt_d    = '0;
    pulse_d  = 1'b0;
    strobe_d = 1'b0;
    if (run) begin
      if (sum >= {1'b0, cts_q}) begin
        acc_d    = sum - {1'b0, cts_q};
        pulse_d  = 1'b1;
        cnt_d    = cnt_q + 7'd1;
        strobe_d = (cnt_q == 7'd127);
      end else begin
        acc_d = sum;
        cnt_d = cnt_q;
      end
    end
  end

  always_comb begin
    acr_locked        = (state_q == LOCKED);
    n_value           = n_q;
    cts_value         = cts_q;
    clk_audio_x128_en = pulse_q;
    sample_strobe     = strobe_q;
    packet_error      = err_q;
  end
endmodule
